key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Multi-channel push-button conditioner placed directly upstream of the stopwatch top level, between the board KEY pins and the stopwatch's edge-detect stage.
- Synchronises each raw active-low key and filters contact bounce with a per-key stability counter.
- Delivers a clean active-low level that drops into the existing edge-detect input unchanged.
- Also delivers registered one-cycle press, release and long-press pulses, so the stopwatch can drop its own edge logic if wanted.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, clocks the synchronised input must stay stable before a level change is accepted (20 ms at 50 MHz).
- HOLD_CYCLES, 50000000, clocks a key must stay debounced-pressed before long_press fires (1 s at 50 MHz).
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- key_raw  input  N_KEYS  raw board keys, active-low (0 = pressed), asynchronous to clk.
- key_level  output  N_KEYS  debounced level, active-low, registered.
- pressed  output  N_KEYS  one-cycle pulse on accepted press.
- released  output  N_KEYS  one-cycle pulse on accepted release.
- long_press  output  N_KEYS  one-cycle pulse once per press, after HOLD_CYCLES held.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0, all flops clear immediately, independent of clk:
  - synchroniser flops = 1, key_level = all 1s;
  - pressed = released = long_press = 0;
  - every channel in state UP, counters = 0, hold_done = 0.
- Release: deassertion of rst is not synchronised inside the block; the board reset synchroniser handles it.
- Channels are fully independent; there is no shared state between keys.
- Synchroniser: two flops per key. s = second flop output. Raw-to-s latency is 2 clocks.
- FSM per channel, four states:
  - UP: key_level=1. If s=0, go to WAIT_DN with cnt=0.
  - WAIT_DN: if s=1 (bounce), return to UP with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to DN: key_level<=0, pressed<=1 for one clock, cnt<=0, hold_done<=0. Else cnt+1.
  - DN: key_level=0. If s=1, go to WAIT_UP with cnt=0. Else the hold counter runs:
    - if hold_done=0 and cnt==HOLD_CYCLES-1, long_press<=1 for one clock and hold_done<=1;
    - cnt saturates after that, no repeat.
  - WAIT_UP: if s=0 (bounce), return to DN. Restore cnt to HOLD_CYCLES-1 only if hold_done=1, otherwise clear it so the hold timing restarts. Else if cnt==DEBOUNCE_CYCLES-1, go to UP: key_level<=1, released<=1 for one clock. Else cnt+1.
- Latency: a clean raw press stable from cycle 0 gives key_level falling and pressed high in cycle 2+DEBOUNCE_CYCLES. Release is symmetric.
- Pulses are registered and last exactly one clock. pressed and released are never high together on the same channel.
- Glitches shorter than DEBOUNCE_CYCLES in either direction produce no output change and no pulse.
- Reset mid-count (any state): the channel returns to UP and emits no pulses. A key physically held through reset is re-debounced after reset and yields a fresh pressed.
- Long-press cannot fire before pressed, and fires at most once per press.
- A key released before HOLD_CYCLES gives released only.
- Arithmetic: cnt is unsigned CNT_W bits and never wraps (saturates at HOLD_CYCLES-1 in DN).

Decomposition:
- Shared package holds:
  - the FSM state encoding constants UP, WAIT_DN, DN, WAIT_UP (2-bit);
  - CLOCK_FRQ = 50000000;
  - the derived defaults for DEBOUNCE_CYCLES and HOLD_CYCLES from CLOCK_FRQ.
- One sub-module: key_debounce_ch (single key: synchroniser, FSM, counter, three pulses). The top level instantiates it N_KEYS times with a generate loop.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, N_KEYS=4.
- Clean press: key_raw[0] 1->0 at cycle 10, held -> pressed[0]=1 only at cycle 20, key_level[0]=0 from cycle 20; other channels stay 1/0.
- Bounce: key_raw[1] toggles 0/1 every 3 cycles for 30 cycles, then held 0 -> exactly one pressed[1] pulse, 10 cycles after the final stable 0; no released pulse.
- Long press: key_raw[2]=0 for 60 cycles then 1 -> pressed at +10, long_press exactly once 32 cycles after pressed, released 10 cycles after the raw release.
- Short press: key_raw[3]=0 for 20 cycles -> pressed and released fire once each, long_press never fires.
- Async reset mid-WAIT_DN: rst=0 at cycle 5 of a pending press, between clock edges -> outputs reset immediately without a clk edge, no pulse. After rst=1 with the key still 0 -> pressed 10 cycles later.
- Simultaneous keys: all four keys low in the same cycle -> four pressed pulses in the same cycle; glitch of 5 cycles on key 0 during DN -> no released pulse.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
// Timing defaults are derived from the 50 MHz system clock.
package key_debounce_pkg;

  localparam int unsigned CLOCK_FRQ           = 50_000_000;
  // 20 ms debounce window, 1 s long-press threshold
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLOCK_FRQ / 50;
  localparam int unsigned HOLD_CYCLES_DEF     = CLOCK_FRQ;
  localparam int unsigned CNT_W_DEF           = 26;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DN      = 2'd2,
    WAIT_UP = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: two-flop synchroniser, debounce FSM with a shared
// stability/hold counter, and registered press/release/long-press pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_done_q, hold_done_d;
  logic             level_q, level_d;
  logic             pressed_q, pressed_d;
  logic             released_q, released_d;
  logic             long_q, long_d;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      state_q     <= UP;
      cnt_q       <= '0;
      hold_done_q <= 1'b0;
      level_q     <= 1'b1;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_done_q <= hold_done_d;
      level_q     <= level_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    sync_d      = {sync_q[0], key_raw};
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_done_d = hold_done_q;
    level_d     = level_q;
    pressed_d   = 1'b0;
    released_d  = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      UP: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = WAIT_DN;
          cnt_d   = '0;
        end
      end

      WAIT_DN: begin
        if (s) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = DN;
          level_d     = 1'b0;
          pressed_d   = 1'b1;
          cnt_d       = '0;
          hold_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DN: begin
        level_d = 1'b0;
        if (s) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end else if (!hold_done_q && cnt_q == HOLD_LAST) begin
          long_d      = 1'b1;
          hold_done_d = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          // Counter parks at HOLD_LAST so long_press never repeats
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_UP: begin
        if (!s) begin
          state_d = DN;
          cnt_d   = hold_done_q ? HOLD_LAST : '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = UP;
          level_d    = 1'b1;
          released_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level  = level_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign long_press = long_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key push-button conditioner: one independent debounce channel per
// active-low board key, giving a clean level plus press/release/long pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] released,
  output logic [N_KEYS-1:0] long_press
);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
      key_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw[gi]),
        .key_level (key_level[gi]),
        .pressed   (pressed[gi]),
        .released  (released[gi]),
        .long_press(long_press[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/hold windows; pulse
// counts and pulse cycles are logged every cycle and checked against hand values.
module tb_key_debounce;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_raw = '1;
  logic [N-1:0] key_level, pressed, released, long_press;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_level (key_level),
    .pressed   (pressed),
    .released  (released),
    .long_press(long_press)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int overlap = 0;
  int p_cnt[N], p_cyc[N], r_cnt[N], r_cyc[N], l_cnt[N], l_cyc[N];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < N; i++) begin
      p_cnt[i] = 0; p_cyc[i] = -1;
      r_cnt[i] = 0; r_cyc[i] = -1;
      l_cnt[i] = 0; l_cyc[i] = -1;
    end
  endtask

  // Advance to the next falling edge and log every pulse seen there
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pressed[i])    begin p_cnt[i]++; p_cyc[i] = cyc; end
      if (released[i])   begin r_cnt[i]++; r_cyc[i] = cyc; end
      if (long_press[i]) begin l_cnt[i]++; l_cyc[i] = cyc; end
    end
    if ((pressed & released) != '0) overlap++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles, expected under 1000", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int r;
    clear_log();

    // Power-on reset
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_level", int'(key_level), 15);
    check_eq("reset_pulses", int'(pressed | released | long_press), 0);
    rst = 1'b1;
    cyc = 0;

    // Clean press on key 0: raw sampled low at edge 10, pressed at 20
    run_to(9);
    key_raw[0] = 1'b0;
    run_to(19);
    check_eq("clean_level_before", int'(key_level), 15);
    run_to(20);
    check_eq("clean_pressed", int'(pressed), 1);
    check_eq("clean_level", int'(key_level), 14);
    run_to(21);
    check_eq("clean_pressed_1cyc", int'(pressed), 0);
    key_raw[0] = 1'b1;
    run_to(40);
    check_eq("clean_press_count", p_cnt[0], 1);
    check_eq("clean_release_cyc", r_cyc[0], 32);
    check_eq("clean_no_long", l_cnt[0], 0);
    check_eq("clean_others_quiet", p_cnt[1] + p_cnt[2] + p_cnt[3], 0);

    // Bounce on key 1: 3-cycle toggling for 30 cycles, then stable low
    clear_log();
    b = cyc;
    for (int k = 0; k < 30; k++) begin
      key_raw[1] = ((k / 3) % 2) ? 1'b1 : 1'b0;
      tick();
    end
    key_raw[1] = 1'b0;
    run_to(b + 45);
    check_eq("bounce_press_count", p_cnt[1], 1);
    check_eq("bounce_press_cyc", p_cyc[1], b + 41);
    check_eq("bounce_no_release", r_cnt[1], 0);
    key_raw[1] = 1'b1;
    run_to(b + 60);
    check_eq("bounce_release_count", r_cnt[1], 1);

    // Long press on key 2: low for 60 cycles
    clear_log();
    b = cyc;
    key_raw[2] = 1'b0;
    run_to(b + 60);
    key_raw[2] = 1'b1;
    run_to(b + 80);
    check_eq("long_press_cyc", p_cyc[2], b + 11);
    check_eq("long_count", l_cnt[2], 1);
    check_eq("long_cyc", l_cyc[2], b + 43);
    check_eq("long_release_cyc", r_cyc[2], b + 71);

    // Short press on key 3: low for 20 cycles
    clear_log();
    b = cyc;
    key_raw[3] = 1'b0;
    run_to(b + 20);
    key_raw[3] = 1'b1;
    run_to(b + 80);
    check_eq("short_press_cyc", p_cyc[3], b + 11);
    check_eq("short_release_cyc", r_cyc[3], b + 31);
    check_eq("short_no_long", l_cnt[3], 0);

    // Async reset with key 3 held down and key 0 mid-debounce
    clear_log();
    b = cyc;
    key_raw[3] = 1'b0;
    run_to(b + 12);
    key_raw[0] = 1'b0;
    run_to(b + 17);
    check_eq("pre_reset_level", int'(key_level), 7);
    #2 rst = 1'b0;
    #1;
    check_eq("async_reset_level", int'(key_level), 15);
    check_eq("async_reset_pulses", int'(pressed | released | long_press), 0);
    clear_log();
    tick(); tick(); tick();
    rst = 1'b1;
    r = cyc;
    run_to(r + 10);
    check_eq("post_reset_quiet", p_cnt[0] + p_cnt[3] + r_cnt[3], 0);
    run_to(r + 11);
    check_eq("post_reset_pressed", int'(pressed), 9);
    key_raw = '1;
    run_to(r + 30);
    check_eq("post_reset_released", r_cnt[0] + r_cnt[3], 2);

    // All keys together, then a 5-cycle glitch on key 0 while down
    clear_log();
    b = cyc;
    key_raw = '0;
    run_to(b + 11);
    check_eq("simul_pressed", int'(pressed), 15);
    run_to(b + 15);
    key_raw[0] = 1'b1;
    run_to(b + 20);
    key_raw[0] = 1'b0;
    run_to(b + 60);
    check_eq("glitch_no_release", r_cnt[0], 0);
    check_eq("glitch_level", int'(key_level), 0);
    check_eq("glitch_long_restart", l_cyc[0], b + 55);
    check_eq("simul_long_key1", l_cyc[1], b + 43);
    key_raw = '1;
    run_to(b + 75);
    check_eq("simul_released_all", r_cnt[0] + r_cnt[1] + r_cnt[2] + r_cnt[3], 4);

    check_eq("press_release_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
